// File: rtl/hram_host_bridge.sv
// hram_host_bridge: byte-stream command front-end for the hyper_xface HyperRAM controller.
// Frames are one command byte plus PB payload bytes; every command returns one PB-byte word.
module hram_host_bridge #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 32,
    parameter int unsigned MAX_BURST = 16,
    parameter logic [7:0]  LAT_1X    = 8'h10,
    parameter logic [7:0]  LAT_2X    = 8'd22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              xf_rd_req,
    output logic              xf_wr_req,
    output logic [AW-1:0]     xf_addr,
    output logic [DW-1:0]     xf_wr_d,
    output logic [DW/8-1:0]   xf_wr_byte_en,
    output logic [5:0]        xf_rd_num_dwords,
    input  logic [DW-1:0]     xf_rd_d,
    input  logic              xf_rd_rdy,
    input  logic              xf_busy,
    output logic [7:0]        latency_1x,
    output logic [7:0]        latency_2x,
    output logic              mem_or_reg,
    output logic              err
);

    localparam int unsigned   PB       = DW / 8;
    localparam int unsigned   IW       = $clog2(MAX_BURST);
    localparam int unsigned   CW       = $clog2(PB + 2);
    localparam logic [CW-1:0] LastRx   = CW'(PB);
    localparam logic [6:0]    MaxBurst = 7'(MAX_BURST);
    localparam logic [DW-1:0] ErrW     = '1;

    localparam logic [7:0] CmdAddr    = 8'h01;
    localparam logic [7:0] CmdLoad    = 8'h02;
    localparam logic [7:0] CmdWrite   = 8'h03;
    localparam logic [7:0] CmdRead    = 8'h04;
    localparam logic [7:0] CmdReadReq = 8'h05;
    localparam logic [7:0] CmdCfg     = 8'h06;

    typedef enum logic [2:0] {
        StRx,
        StExec,
        StIssue,
        StCollect,
        StTxSend,
        StTxWait
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [7:0]      cmd_q;
    logic [DW-1:0]   payload_q;
    logic [DW-1:0]   resp_q;
    logic [5:0]      burst_len_q;
    logic [5:0]      idx_q;
    logic [DW-1:0]   rd_buf_q [MAX_BURST];

    logic            tx_start_q;
    logic [7:0]      tx_data_q;
    logic            rd_req_q;
    logic            wr_req_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wr_d_q;
    logic [PB-1:0]   byte_en_q;
    logic [5:0]      num_dw_q;
    logic [7:0]      lat_1x_q;
    logic [7:0]      lat_2x_q;
    logic            mem_or_reg_q;
    logic            err_q;

    logic [5:0]      req_n;
    logic            n_bad;
    logic [IW-1:0]   rd_idx;
    logic            idx_bad;
    logic            buf_we;
    logic [DW-1:0]   resp_word;
    logic            exec_err;
    logic            exec_issue;

    assign req_n   = payload_q[5:0];
    assign n_bad   = (req_n == 6'd0) || ({1'b0, req_n} > MaxBurst);
    assign rd_idx  = payload_q[IW-1:0];
    assign idx_bad = 6'(rd_idx) >= burst_len_q;
    assign buf_we  = (state_q == StCollect) && xf_rd_rdy;

    // Response word and error outcome of the command being executed.
    always_comb begin
        resp_word  = payload_q;
        exec_err   = 1'b0;
        exec_issue = 1'b0;
        case (cmd_q)
            CmdAddr, CmdLoad, CmdCfg: resp_word = payload_q;
            CmdWrite: begin
                resp_word  = DW'(CmdWrite);
                exec_issue = 1'b1;
            end
            CmdRead: begin
                if (idx_bad) begin
                    resp_word = ErrW;
                    exec_err  = 1'b1;
                end else begin
                    resp_word = rd_buf_q[rd_idx];
                end
            end
            CmdReadReq: begin
                if (n_bad) begin
                    resp_word = ErrW;
                    exec_err  = 1'b1;
                end else begin
                    resp_word  = DW'(req_n);
                    exec_issue = 1'b1;
                end
            end
            default: begin
                resp_word = ErrW;
                exec_err  = 1'b1;
            end
        endcase
    end

    // Read buffer has no reset: contents persist across commands and resets.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            rd_buf_q[idx_q[IW-1:0]] <= xf_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StRx;
            rx_cnt_q     <= '0;
            tx_cnt_q     <= '0;
            cmd_q        <= '0;
            payload_q    <= '0;
            resp_q       <= '0;
            burst_len_q  <= '0;
            idx_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            addr_q       <= '0;
            wr_d_q       <= '0;
            byte_en_q    <= '1;
            num_dw_q     <= 6'd1;
            lat_1x_q     <= LAT_1X;
            lat_2x_q     <= LAT_2X;
            mem_or_reg_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            if (rx_valid && (state_q != StRx)) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StRx: begin
                    if (rx_valid) begin
                        if (rx_cnt_q == '0) begin
                            cmd_q <= rx_data;
                        end else begin
                            payload_q <= {payload_q[DW-9:0], rx_data};
                        end
                        if (rx_cnt_q == LastRx) begin
                            rx_cnt_q <= '0;
                            state_q  <= StExec;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + CW'(1);
                        end
                    end
                end
                StExec: begin
                    case (cmd_q)
                        CmdAddr: addr_q <= payload_q[AW-1:0];
                        CmdLoad: wr_d_q <= payload_q;
                        CmdReadReq: begin
                            if (!n_bad) begin
                                num_dw_q    <= req_n;
                                burst_len_q <= req_n;
                                idx_q       <= '0;
                            end
                        end
                        CmdCfg: begin
                            lat_2x_q     <= payload_q[7:0];
                            lat_1x_q     <= payload_q[15:8];
                            mem_or_reg_q <= payload_q[16];
                            byte_en_q    <= payload_q[DW-1:DW-PB];
                        end
                        default: ;
                    endcase
                    if (exec_err) begin
                        err_q <= 1'b1;
                    end
                    if (exec_issue) begin
                        resp_q   <= resp_word;
                        tx_cnt_q <= CW'(PB);
                        state_q  <= StIssue;
                    end else if (tx_ready) begin
                        // Launch the first byte straight away to save a cycle of latency.
                        tx_start_q <= 1'b1;
                        tx_data_q  <= resp_word[DW-1 -: 8];
                        resp_q     <= resp_word << 8;
                        tx_cnt_q   <= CW'(PB - 1);
                        state_q    <= StTxWait;
                    end else begin
                        resp_q   <= resp_word;
                        tx_cnt_q <= CW'(PB);
                        state_q  <= StTxSend;
                    end
                end
                StIssue: begin
                    if (!xf_busy) begin
                        if (cmd_q == CmdWrite) begin
                            wr_req_q <= 1'b1;
                            state_q  <= StTxSend;
                        end else begin
                            rd_req_q <= 1'b1;
                            state_q  <= StCollect;
                        end
                    end
                end
                StCollect: begin
                    if (xf_rd_rdy) begin
                        idx_q <= idx_q + 6'd1;
                        if ((idx_q + 6'd1) == burst_len_q) begin
                            state_q <= StTxSend;
                        end
                    end
                end
                StTxSend: begin
                    if (tx_ready) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= resp_q[DW-1 -: 8];
                        resp_q     <= resp_q << 8;
                        tx_cnt_q   <= tx_cnt_q - CW'(1);
                        state_q    <= StTxWait;
                    end
                end
                StTxWait: begin
                    // Ready may lag tx_start; only move on once it has dropped.
                    if (!tx_ready) begin
                        state_q <= (tx_cnt_q == '0) ? StRx : StTxSend;
                    end
                end
                default: state_q <= StRx;
            endcase
        end
    end

    assign tx_start         = tx_start_q;
    assign tx_data          = tx_data_q;
    assign xf_rd_req        = rd_req_q;
    assign xf_wr_req        = wr_req_q;
    assign xf_addr          = addr_q;
    assign xf_wr_d          = wr_d_q;
    assign xf_wr_byte_en    = byte_en_q;
    assign xf_rd_num_dwords = num_dw_q;
    assign latency_1x       = lat_1x_q;
    assign latency_2x       = lat_2x_q;
    assign mem_or_reg       = mem_or_reg_q;
    assign err              = err_q;

endmodule
